// File: rtl/alu_core.sv
// Registered 32-bit integer ALU (MIPS R-type funct codes) with N/Z/C/V flags, one-cycle latency.
// Define ALU_SHIFT_EN to build the barrel shifter for SLL/SRL/SRA; otherwise those codes decode as unlisted.
module alu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [5:0]  func,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  typedef enum logic [5:0] {
    FN_SLL  = 6'h04,
    FN_SRL  = 6'h06,
    FN_SRA  = 6'h07,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } func_e;

  logic [32:0] sum_ext;
  logic [31:0] diff;
  logic [31:0] b_neg;
  logic        add_ovf;
  logic        sub_ovf;
  logic        borrow;
  logic        lt_signed;

  logic [31:0] res_nxt;
  logic        c_nxt;
  logic        v_nxt;

  always_comb begin
    sum_ext   = {1'b0, operand_a} + {1'b0, operand_b};
    diff      = operand_a - operand_b;
    b_neg     = ~operand_b + 32'd1;
    add_ovf   = (operand_a[31] == operand_b[31]) && (sum_ext[31] != operand_a[31]);
    sub_ovf   = (operand_a[31] == b_neg[31]) && (diff[31] != operand_a[31]);
    borrow    = operand_a < operand_b;
    lt_signed = $signed(operand_a) < $signed(operand_b);
  end

  always_comb begin
    res_nxt = '0;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
    case (func)
      FN_ADD:  begin res_nxt = sum_ext[31:0]; c_nxt = sum_ext[32]; v_nxt = add_ovf; end
      FN_ADDU: begin res_nxt = sum_ext[31:0]; c_nxt = sum_ext[32]; end
      FN_SUB:  begin res_nxt = diff; c_nxt = borrow; v_nxt = sub_ovf; end
      FN_SUBU: begin res_nxt = diff; c_nxt = borrow; end
      FN_AND:  res_nxt = operand_a & operand_b;
      FN_OR:   res_nxt = operand_a | operand_b;
      FN_XOR:  res_nxt = operand_a ^ operand_b;
      FN_NOR:  res_nxt = ~(operand_a | operand_b);
      FN_SLT:  res_nxt = {31'd0, lt_signed};
      FN_SLTU: res_nxt = {31'd0, borrow};
`ifdef ALU_SHIFT_EN
      FN_SLL:  res_nxt = operand_a << operand_b[4:0];
      FN_SRL:  res_nxt = operand_a >> operand_b[4:0];
      FN_SRA:  res_nxt = $unsigned($signed(operand_a) >>> operand_b[4:0]);
`endif
      default: res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else begin
      result <= res_nxt;
      flags  <= {res_nxt[31], (res_nxt == '0), c_nxt, v_nxt};
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: reset behaviour, every op, flag corners, latency and mid-stream reset.
module tb_alu_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [5:0]  func;
  logic [31:0] result;
  logic [3:0]  flags;

  int unsigned n_applied;
  int unsigned n_miscompare;

  alu_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .func      (func),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [3:0]  exp_flg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] exp_res, input logic [3:0] exp_flg);
    n_applied++;
    if (result !== exp_res || flags !== exp_flg) begin
      n_miscompare++;
      $display("FAIL %s: result=%h flags=%b, expected result=%h flags=%b",
               name, result, flags, exp_res, exp_flg);
    end
  endtask

  task automatic add_vec(input string name, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.name = name; v.fn = fn; v.a = a; v.b = b; v.exp_res = r; v.exp_flg = f;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t prev;
    n_applied    = 0;
    n_miscompare = 0;

    // flags column is {N,Z,C,V}
    add_vec("add_100_75",    6'h20, 32'd100,        32'd75,         32'd175,        4'b0000);
    add_vec("add_1024_2048", 6'h20, 32'd1024,       32'd2048,       32'd3072,       4'b0000);
    add_vec("add_ovf",       6'h20, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001);
    add_vec("add_carry",     6'h20, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0110);
    add_vec("addu_noovf",    6'h21, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1000);
    add_vec("addu_carry",    6'h21, 32'hFFFF_FFFF,  32'd2,          32'd1,          4'b0010);
    add_vec("sub_7_7",       6'h22, 32'd7,          32'd7,          32'd0,          4'b0100);
    add_vec("sub_99_1",      6'h22, 32'd99,         32'd1,          32'd98,         4'b0000);
    add_vec("sub_9999",      6'h22, 32'd9999,       32'd9999,       32'd0,          4'b0100);
    add_vec("sub_neg999",    6'h22, 32'd9999,       -32'sd999,      32'd10998,      4'b0010);
    add_vec("sub_1_2",       6'h22, 32'd1,          32'd2,          32'hFFFF_FFFF,  4'b1010);
    add_vec("sub_ovf",       6'h22, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0001);
    add_vec("subu_noovf",    6'h23, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0000);
    add_vec("and",           6'h24, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F,  4'b0000);
    add_vec("or",            6'h25, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'hFFF0_0FFF,  4'b1000);
    add_vec("xor",           6'h26, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'hFF00_0FF0,  4'b1000);
    add_vec("nor",           6'h27, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h000F_F000,  4'b0000);
    add_vec("slt_m1_1",      6'h2A, 32'hFFFF_FFFF,  32'd1,          32'd1,          4'b0000);
    add_vec("sltu_m1_1",     6'h2B, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0100);
    add_vec("slt_1_m1",      6'h2A, 32'd1,          32'hFFFF_FFFF,  32'd0,          4'b0100);
    add_vec("sltu_1_m1",     6'h2B, 32'd1,          32'hFFFF_FFFF,  32'd1,          4'b0000);
    add_vec("unlisted_3f",   6'h3F, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          4'b0100);
`ifdef ALU_SHIFT_EN
    add_vec("sra_4",         6'h07, 32'h8000_0000,  32'd4,          32'hF800_0000,  4'b1000);
    add_vec("sll_33",        6'h04, 32'd1,          32'd33,         32'd2,          4'b0000);
    add_vec("srl_31",        6'h06, 32'h8000_0000,  32'd31,         32'd1,          4'b0000);
`else
    add_vec("sra_off",       6'h07, 32'h8000_0000,  32'd4,          32'd0,          4'b0100);
    add_vec("sll_off",       6'h04, 32'd1,          32'd33,         32'd0,          4'b0100);
    add_vec("srl_off",       6'h06, 32'h8000_0000,  32'd31,         32'd0,          4'b0100);
`endif

    // Reset held with nonzero inputs presented
    rst_n = 1'b0; func = 6'h20; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1111_1111;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 32'd0, 4'b0000);

    // Release between edges: outputs stay zero until the next rising edge
    @(negedge clk);
    rst_n = 1'b1; func = vecs[0].fn; operand_a = vecs[0].a; operand_b = vecs[0].b;
    #1 check("post_release_pre_edge", 32'd0, 4'b0000);
    @(posedge clk);
    #1 check(vecs[0].name, vecs[0].exp_res, vecs[0].exp_flg);
    prev = vecs[0];

    // Back-to-back: new inputs every cycle, previous result must hold until the next edge
    for (int i = 1; i < vecs.size(); i++) begin
      @(negedge clk);
      func = vecs[i].fn; operand_a = vecs[i].a; operand_b = vecs[i].b;
      #1 check({"hold_", prev.name}, prev.exp_res, prev.exp_flg);
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_flg);
      prev = vecs[i];
    end

    // Mid-stream asynchronous reset clears outputs without a clock edge
    @(negedge clk);
    func = 6'h20; operand_a = 32'd100; operand_b = 32'd75;
    @(posedge clk);
    #1 check("pre_midreset_add", 32'd175, 4'b0000);
    #2 rst_n = 1'b0;
    #1 check("midreset_async", 32'd0, 4'b0000);
    @(posedge clk);
    #1 check("midreset_held", 32'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; operand_a = 32'd1; operand_b = 32'd2;
    #1 check("midreset_release_pre_edge", 32'd0, 4'b0000);
    @(posedge clk);
    #1 check("midreset_first_update", 32'd3, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule
